mpu_operand_loader: RTL
=======================

Name: mpu_operand_loader

Overview:
- Upstream stage of the element-wise matrix subtract unit.
- Takes a serial byte stream of 50 elements: matrix A first, then matrix B.
- Assembles both into flattened 5x5 int8 buses and presents them as one operand pair on a valid/ready handshake.
- The subtract stage consumes matrix_a/matrix_b combinationally while out_valid is high.

Parameters:
- N, 5, matrix dimension (square N x N).
- W, 8, element width in bits.
- ELEMS, N*N, elements per matrix (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  W  element byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- abort  input  1  synchronous discard of a partial load.
- matrix_a  output  W*ELEMS  flattened A; element (i,j) at bits [W*(i+N*j) +: W].
- matrix_b  output  W*ELEMS  flattened B; same layout.
- out_valid  output  1  matrix_a/matrix_b hold a complete pair.
- out_ready  input  1  downstream consumes the pair.
- load_idx  output  $clog2(ELEMS)  index of the next element to be written.
- load_phase  output  1  0 = filling A, 1 = filling B.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. rst_n sampled only at a rising clk edge.
- Reset (rst_n=0 at edge) drives:
  - state LOAD_A, load_idx 0, load_phase 0.
  - out_valid 0.
  - matrix_a and matrix_b all zero.
  - in_ready rises the cycle after reset deasserts.
- Accept event: in_valid && in_ready at a rising edge.
- Element order:
  - Stream element k (k=0..24) of each matrix writes bits [W*k +: W], so k = i + N*j.
  - The first byte received lands in the LSB element.
- States:
  - LOAD_A:
    - in_ready=1, out_valid=0.
    - Each accept writes matrix_a[W*load_idx +: W] and increments load_idx.
    - Accept at load_idx=ELEMS-1: load_idx wraps to 0, go to LOAD_B.
  - LOAD_B:
    - Same behaviour, writing matrix_b.
    - Accept at load_idx=ELEMS-1: load_idx wraps to 0, go to FULL.
  - FULL:
    - in_ready=0, out_valid=1.
    - matrix_a/matrix_b held stable.
    - out_valid && out_ready at an edge: go to LOAD_A. Matrix contents stay until overwritten.
- Latency:
  - out_valid asserts the cycle after the 50th accept.
  - A back-to-back stream needs 50 cycles per pair plus 1 drain cycle.
  - No double buffering: in_ready stays 0 in the cycle out_ready is sampled, and rises the next cycle.
- out_valid never depends combinationally on out_ready. in_ready is a registered-state decode only, with no combinational dependence on inputs.
- Unwritten elements of a partially overwritten matrix keep their previous values. This is only observable after an abort.
- abort:
  - In LOAD_A or LOAD_B: go to LOAD_A with load_idx=0. An accept coinciding with abort is discarded (no write).
  - In FULL: ignored. The pair must be drained via out_ready.
  - abort and rst_n=0 together: reset wins.
- Reset mid-load or in FULL: all outputs return to reset values at that edge. The pending pair is lost.
- in_data is don't-care when in_valid=0. No writes occur when in_ready=0.
- Widths:
  - load_idx is wide enough for ELEMS-1 (5 bits at defaults).
  - Values are stored raw. There is no arithmetic or sign handling in this block.

Test Plan:
1. Reset, then stream bytes 1..25 for A and 25..1 for B, in_valid held high, out_ready=0 -> out_valid rises the cycle after the 50th accept. Element (0,0) of A = 1, A element (4,4) at bits [192+:8] = 25, B element (0,0) = 25, B element (4,4) = 1. in_ready=0 and outputs stable for 10 idle cycles.
2. From the FULL state of test 1, pulse out_ready for one cycle -> out_valid=0 and in_ready=1 the next cycle. Load a second pair of all 0x80 (A) and all 0x7F (B) -> new pair presented, no stale bytes.
3. Gapped stream (in_valid toggled 1,0,1,0 …) with 50 elements -> identical result to test 1, and load_idx increments only on accept cycles.
4. After 30 accepts (load_phase=1, load_idx=5), assert abort together with in_valid -> load_idx=0, load_phase=0, matrix_b[0+:8] unchanged. Then 50 fresh bytes 0xAA (A) and 0x55 (B) -> out_valid with the correct pair.
5. Drive rst_n=0 for one cycle at load_idx=12 of A -> matrices all zero, out_valid=0, load_idx=0. Also assert rst_n=0 while in FULL -> out_valid drops at that edge.
6. Assert abort while in FULL -> no change, out_valid stays 1. Then out_ready=1 drains normally.

Source files
------------

// File: rtl/mpu_operand_loader.sv
// mpu_operand_loader: assembles a 50-byte stream (A then B) into a 5x5 int8 operand pair behind a valid/ready handshake
module mpu_operand_loader #(
  parameter  int N     = 5,
  parameter  int W     = 8,
  localparam int ELEMS = N * N,
  localparam int IW    = $clog2(ELEMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [W*ELEMS-1:0] matrix_a,
  output logic [W*ELEMS-1:0] matrix_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    load_idx,
  output logic             load_phase
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W*ELEMS-1:0] ma_q, ma_d, mb_q, mb_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic acc, last;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc     = in_valid && in_ready_q;
    last    = idx_q == IW'(ELEMS - 1);
    if (state_q == FULL) begin
      if (out_ready) state_d = LOAD_A;
    end else if (abort) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else if (acc) begin
      if (state_q == LOAD_A) ma_d[W*idx_q +: W] = in_data;
      else mb_d[W*idx_q +: W] = in_data;
      idx_d = last ? '0 : idx_q + 1'b1;
      if (last) state_d = (state_q == LOAD_A) ? LOAD_B : FULL;
    end
    // handshake flags are registered from the next state so they never see inputs combinationally
    in_ready_d  = state_d != FULL;
    out_valid_d = state_d == FULL;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign matrix_a   = ma_q;
  assign matrix_b   = mb_q;
  assign load_idx   = idx_q;
  assign load_phase = state_q == LOAD_B;
endmodule
